// File: rtl/frame_display_pkg.sv
// Shared video definitions: visible resolution, frame-buffer address width and the
// 24-bit colour bundle used by the sync generator, frame-buffer writer and display back-end.
package frame_display_pkg;

  localparam int unsigned H_RES  = 640;
  localparam int unsigned V_RES  = 480;
  localparam int unsigned ADDR_W = 19;

  typedef struct packed {
    logic [7:0] Red;
    logic [7:0] Green;
    logic [7:0] Blue;
  } rgb24_t;

endpackage

// File: rtl/frame_display_rgb332_expand.sv
// RGB332 to 24-bit RGB by bit replication, so full-scale codes map to 0xFF exactly.
module rgb332_expand
  import frame_display_pkg::*;
(
  input  logic [7:0] code,
  output rgb24_t     rgb
);

  always_comb begin
    rgb       = '0;
    rgb.Red   = {code[7:5], code[7:5], code[7:6]};
    rgb.Green = {code[4:2], code[4:2], code[4:3]};
    rgb.Blue  = {code[1:0], code[1:0], code[1:0], code[1:0]};
  end

endmodule

// File: rtl/frame_display.sv
// Pixel back-end: coordinate to frame-buffer address, visibility pipeline aligned with the
// RAM read latency, and RGB332 expansion registered on each pixel_clk rising edge.
module frame_display #(
  parameter int unsigned H_RES = frame_display_pkg::H_RES,
  parameter int unsigned V_RES = frame_display_pkg::V_RES
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        pixel_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [7:0]  frame_output,
  output logic [18:0] frame_rdAddress,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue
);

  import frame_display_pkg::*;

  localparam logic [9:0] HLimit = 10'(H_RES);
  localparam logic [9:0] VLimit = 10'(V_RES);

  logic                visible;
  logic [ADDR_W-1:0]   address;
  logic [ADDR_W-1:0]   y_ext;
  logic [ADDR_W-1:0]   x_ext;
  logic                vis1_q;
  logic                vis2_q;
  logic                pclk_q;
  logic                strobe;
  rgb24_t              expanded;
  rgb24_t              rgb_q;

  // DrawY*640 + DrawX without a multiplier; max visible result 307199 fits 19 bits.
  always_comb begin
    visible = (DrawX < HLimit) && (DrawY < VLimit);
    y_ext   = {{(ADDR_W - 10){1'b0}}, DrawY};
    x_ext   = {{(ADDR_W - 10){1'b0}}, DrawX};
    address = '0;
    if (visible) begin
      address = (y_ext << 9) + (y_ext << 7) + x_ext;
    end
  end

  assign strobe = pixel_clk & ~pclk_q;

  rgb332_expand u_expand (
    .code (frame_output),
    .rgb  (expanded)
  );

  always_ff @(posedge Clk) begin
    if (!reset) begin
      frame_rdAddress <= '0;
      vis1_q          <= 1'b0;
      vis2_q          <= 1'b0;
      pclk_q          <= 1'b0;
      rgb_q           <= '0;
    end else begin
      frame_rdAddress <= address;
      vis1_q          <= visible;
      // vis2_q lines up with frame_output, which lags frame_rdAddress by one Clk.
      vis2_q          <= vis1_q;
      pclk_q          <= pixel_clk;
      if (strobe) begin
        rgb_q <= vis2_q ? expanded : '0;
      end
    end
  end

  assign Red   = rgb_q.Red;
  assign Green = rgb_q.Green;
  assign Blue  = rgb_q.Blue;

endmodule

// File: tb/tb_frame_display.sv
// Randomized bench for frame_display with a history-based reference model and directed
// literal checks for addressing, colour expansion, blanking, gating and reset.
module tb_frame_display;

  logic        Clk = 1'b0;
  logic        reset;
  logic        pixel_clk;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [7:0]  frame_output;
  logic [18:0] frame_rdAddress;
  logic [7:0]  Red;
  logic [7:0]  Green;
  logic [7:0]  Blue;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  frame_display dut (
    .Clk             (Clk),
    .reset           (reset),
    .pixel_clk       (pixel_clk),
    .DrawX           (DrawX),
    .DrawY           (DrawY),
    .frame_output    (frame_output),
    .frame_rdAddress (frame_rdAddress),
    .Red             (Red),
    .Green           (Green),
    .Blue            (Blue)
  );

  always #10 Clk = ~Clk;

  // Reference: n-bit channel scaled to 0..255 with rounding.
  function automatic int scale3(input int v);
    return (v * 510 + 7) / 14;
  endfunction

  function automatic int exp_r(input logic [7:0] c);
    return scale3(int'(c[7:5]));
  endfunction

  function automatic int exp_g(input logic [7:0] c);
    return scale3(int'(c[4:2]));
  endfunction

  function automatic int exp_b(input logic [7:0] c);
    return int'(c[1:0]) * 85;
  endfunction

  function automatic bit is_vis(input logic [9:0] x, input logic [9:0] y);
    return (int'(x) < 640) && (int'(y) < 480);
  endfunction

  // Model: visibility history of coordinates sampled since the last reset edge.
  bit vis_hist[$];
  bit m_pix_prev = 1'b0;
  int m_addr = 0;
  int m_r = 0;
  int m_g = 0;
  int m_b = 0;

  function automatic bit shown_vis();
    if (vis_hist.size() >= 2) return vis_hist[vis_hist.size() - 2];
    return 1'b0;
  endfunction

  always @(posedge Clk) begin
    if (!reset) begin
      m_addr     <= 0;
      m_r        <= 0;
      m_g        <= 0;
      m_b        <= 0;
      m_pix_prev <= 1'b0;
      vis_hist.delete();
    end else begin
      m_addr <= is_vis(DrawX, DrawY) ? int'(DrawY) * 640 + int'(DrawX) : 0;
      if (pixel_clk && !m_pix_prev) begin
        m_r <= shown_vis() ? exp_r(frame_output) : 0;
        m_g <= shown_vis() ? exp_g(frame_output) : 0;
        m_b <= shown_vis() ? exp_b(frame_output) : 0;
      end
      m_pix_prev <= pixel_clk;
      vis_hist.push_back(is_vis(DrawX, DrawY));
      if (vis_hist.size() > 2) vis_hist.pop_front();
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (started) begin
      check("model_addr", int'(frame_rdAddress), m_addr);
      check("model_red", int'(Red), m_r);
      check("model_green", int'(Green), m_g);
      check("model_blue", int'(Blue), m_b);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  // Fill the pipeline with a visible pixel, then strobe and check the literal colour.
  task automatic show(input logic [7:0] c, input logic [9:0] x, input logic [9:0] y,
                      input int r, input int g, input int b, input string name);
    pixel_clk    = 1'b0;
    DrawX        = x;
    DrawY        = y;
    frame_output = c;
    step(3);
    pixel_clk = 1'b1;
    step(1);
    check({name, "_r"}, int'(Red), r);
    check({name, "_g"}, int'(Green), g);
    check({name, "_b"}, int'(Blue), b);
  endtask

  task automatic addr_chk(input int x, input int y, input int req, input string name);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step(1);
    check(name, int'(frame_rdAddress), req);
  endtask

  initial begin
    reset        = 1'b0;
    pixel_clk    = 1'b0;
    DrawX        = '0;
    DrawY        = '0;
    frame_output = '0;
    @(negedge Clk);
    started = 1'b1;

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      pixel_clk    = 1'($urandom);
      DrawX        = 10'($urandom_range(0, 799));
      DrawY        = 10'($urandom_range(0, 524));
      frame_output = 8'($urandom);
      step(1);
      check("reset_addr", int'(frame_rdAddress), 0);
      check("reset_rgb", int'({Red, Green, Blue}), 0);
    end
    reset     = 1'b1;
    pixel_clk = 1'b0;

    addr_chk(0, 0, 0, "addr_0_0");
    addr_chk(639, 0, 639, "addr_639_0");
    addr_chk(0, 1, 640, "addr_0_1");
    addr_chk(639, 479, 307199, "addr_639_479");
    addr_chk(700, 10, 0, "addr_blank_x");
    addr_chk(10, 500, 0, "addr_blank_y");

    show(8'h52, 10'd5, 10'd7, 'h49, 'h92, 'hAA, "col_52");
    // Non-strobe cycles: new data must not reach the outputs.
    frame_output = 8'hFF;
    step(2);
    check("hold_red", int'(Red), 'h49);
    show(8'hFF, 10'd100, 10'd200, 'hFF, 'hFF, 'hFF, "col_ff");
    show(8'h00, 10'd639, 10'd479, 'h00, 'h00, 'h00, "col_00");
    show(8'hE0, 10'd1, 10'd1, 'hFF, 'h00, 'h00, "col_e0");
    show(8'hFF, 10'd700, 10'd10, 0, 0, 0, "blank_x");
    show(8'hFF, 10'd10, 10'd500, 0, 0, 0, "blank_y");

    // Reset mid-frame while showing white.
    show(8'hFF, 10'd20, 10'd20, 'hFF, 'hFF, 'hFF, "pre_rst");
    reset = 1'b0;
    step(1);
    check("mid_rst_rgb", int'({Red, Green, Blue}), 0);
    reset = 1'b1;
    step(1);
    check("post_rst_rgb", int'({Red, Green, Blue}), 0);
    pixel_clk = 1'b0;
    step(2);
    pixel_clk = 1'b1;
    step(1);
    check("refill_red", int'(Red), 'hFF);

    // Randomized traffic: variable pixel_clk phase, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) pixel_clk = ~pixel_clk;
      if ($urandom_range(0, 3) != 0) begin
        DrawX = 10'($urandom_range(0, 799));
        DrawY = 10'($urandom_range(0, 524));
      end
      frame_output = 8'($urandom);
      reset        = ($urandom_range(0, 199) != 0);
      step(1);
    end

    started = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
